ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one simple dual-port RAM (one write port, one registered read port, 1-cycle read latency) between NUM_PORTS requesters.
- Runs independent round-robin arbitration on the write port and the read port, so one write and one read can be granted in the same cycle.
- Drives the RAM enables, addresses and write data.
- Routes each read result back to the requester that issued it, with a per-port valid strobe.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- DATA_WIDTH, 8, RAM word width.
- SIZE, 1024, RAM depth in words; ADDRESS_WIDTH = $clog2(SIZE), derived locally.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_req  input  NUM_PORTS  per-port write request; held until granted.
- wr_address  input  NUM_PORTS*ADDRESS_WIDTH  packed write addresses; port i in slice i.
- wr_data  input  NUM_PORTS*DATA_WIDTH  packed write data.
- wr_gnt  output  NUM_PORTS  one-hot write grant, combinational, same cycle as request.
- rd_req  input  NUM_PORTS  per-port read request; held until granted.
- rd_address  input  NUM_PORTS*ADDRESS_WIDTH  packed read addresses.
- rd_gnt  output  NUM_PORTS  one-hot read grant, combinational.
- rd_valid  output  NUM_PORTS  registered one-hot strobe: rd_data is valid for that port.
- rd_data  output  DATA_WIDTH  read data, broadcast to all ports; qualify with rd_valid.
- ram_w_enable  output  1  to RAM write enable.
- ram_w_address  output  ADDRESS_WIDTH  to RAM write address.
- ram_w_data  output  DATA_WIDTH  to RAM write data.
- ram_r_enable  output  1  to RAM read enable.
- ram_r_address  output  ADDRESS_WIDTH  to RAM read address.
- ram_r_data  input  DATA_WIDTH  from RAM registered read data.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = 0, rd_ptr = 0.
  - rd_valid = 0.
  - All grants and RAM enables are 0 while rst_n is low.
  - An in-flight read (granted in the cycle reset asserts) is discarded; no rd_valid is produced after release.
- Write arbitration (combinational):
  - Winner = first i with wr_req[i] set, scanning wr_ptr, wr_ptr+1, ... modulo NUM_PORTS.
  - wr_gnt = one-hot winner, or 0 if no request.
  - ram_w_enable = |wr_gnt; ram_w_address and ram_w_data are muxed from the winner's slice.
  - With no grant, address and data are don't-care but must be stable (hold the slice at wr_ptr).
- Write pointer update: on a clock edge with a write grant, wr_ptr <= (winner+1) mod NUM_PORTS; otherwise it holds.
  - Wrap: winner NUM_PORTS-1 gives ptr 0.
- Read arbitration: identical scheme using rd_req, rd_ptr and rd_gnt, driving ram_r_enable and ram_r_address.
- Read return:
  - rd_valid <= rd_gnt, registered every cycle.
  - rd_data = ram_r_data, combinational pass-through.
  - Latency from rd_gnt to rd_valid is exactly 1 cycle.
  - Back-to-back grants produce back-to-back rd_valid strobes, one per cycle.
- Throughput: one write plus one read per cycle, sustained.
- A requester deasserts its req in the cycle after it sees its gnt, or keeps req high to request again. A held req re-enters arbitration and is not guaranteed consecutive grants.
- Fairness: with all ports continuously requesting, each port gets exactly one grant per NUM_PORTS cycles on each of the read and write paths.
- Same-cycle read and write to the same address: the RAM returns the old contents (read-before-write). The arbiter does not forward; the new value is visible to reads granted at least one cycle after the write grant.
- Same port requesting read and write in one cycle: both paths arbitrate independently, so both may be granted.
- No other state and no FSM beyond the two pointers and the rd_valid register.
- Requests, addresses and data are sampled only in the cycle of grant; changes to them before grant are legal.

Test Plan:
1. Single port, write then read:
   - Port 2 writes address 0x005, data 0xA5 (wr_gnt=0b0100 the same cycle, ram_w_enable=1).
   - Next cycle port 2 reads 0x005: rd_gnt=0b0100, then one cycle later rd_valid=0b0100 with rd_data=0xA5.
2. Round-robin fairness:
   - All 4 ports hold wr_req after reset.
   - Grants follow 0b0001, 0b0010, 0b0100, 0b1000, 0b0001.
   - The same sequence holds on the read path.
3. Pointer skip and wrap:
   - With wr_ptr=3 and only ports 1 and 3 requesting, port 3 is granted, then port 1 (pointer wraps through 0).
   - Verify wr_ptr=0, then 2.
4. Simultaneous read and write, same address:
   - 0x010 holds 0x11; port 0 writes 0x22 to 0x010 while port 1 reads 0x010.
   - Port 1 gets rd_data=0x11; a following read returns 0x22.
5. Reset mid-operation:
   - Assert rst_n low asynchronously in the cycle after a read grant.
   - rd_valid, all grants and both ram enables go to 0 immediately.
   - After release, the first grants go to port 0 (pointers at 0), and no stale rd_valid appears.
6. Idle:
   - No requests for 10 cycles: ram_w_enable=0, ram_r_enable=0, rd_valid=0, and the pointers are unchanged.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM among NUM_PORTS requesters using independent
// round-robin arbiters on the write and read ports; read data returns after one cycle.

module ram_port_rr_arb #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         req,
  output logic [NUM_PORTS-1:0]         gnt,
  output logic [$clog2(NUM_PORTS)-1:0] sel
);
  localparam int unsigned PTR_W = $clog2(NUM_PORTS);
  localparam int unsigned SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [SUM_W-1:0] cand;
  logic             found;

  // Scan ptr, ptr+1, ... (mod NUM_PORTS); with no winner, sel holds at ptr.
  always_comb begin
    gnt   = '0;
    sel   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = SUM_W'(ptr) + SUM_W'(k);
      if (cand >= SUM_W'(NUM_PORTS)) begin
        cand = cand - SUM_W'(NUM_PORTS);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found                 = 1'b1;
        sel                   = cand[PTR_W-1:0];
        gnt[cand[PTR_W-1:0]]  = 1'b1;
      end
    end
    if (!rst_n) begin
      gnt   = '0;
      found = 1'b0;
      sel   = ptr;
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (found) begin
      ptr_next = (sel == PTR_W'(NUM_PORTS - 1)) ? '0 : sel + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end
endmodule

module ram_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE       = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  wr_req,
  input  logic [NUM_PORTS*$clog2(SIZE)-1:0]     wr_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       wr_data,
  output logic [NUM_PORTS-1:0]                  wr_gnt,
  input  logic [NUM_PORTS-1:0]                  rd_req,
  input  logic [NUM_PORTS*$clog2(SIZE)-1:0]     rd_address,
  output logic [NUM_PORTS-1:0]                  rd_gnt,
  output logic [NUM_PORTS-1:0]                  rd_valid,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  ram_w_enable,
  output logic [$clog2(SIZE)-1:0]               ram_w_address,
  output logic [DATA_WIDTH-1:0]                 ram_w_data,
  output logic                                  ram_r_enable,
  output logic [$clog2(SIZE)-1:0]               ram_r_address,
  input  logic [DATA_WIDTH-1:0]                 ram_r_data
);
  localparam int unsigned ADDRESS_WIDTH = $clog2(SIZE);
  localparam int unsigned PTR_W         = $clog2(NUM_PORTS);

  logic [ADDRESS_WIDTH-1:0] wr_addr_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    wr_data_a [NUM_PORTS];
  logic [ADDRESS_WIDTH-1:0] rd_addr_a [NUM_PORTS];
  logic [PTR_W-1:0]         wr_sel;
  logic [PTR_W-1:0]         rd_sel;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign wr_addr_a[i] = wr_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wr_data_a[i] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign rd_addr_a[i] = rd_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  end

  ram_port_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt),
    .sel   (wr_sel)
  );

  ram_port_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt),
    .sel   (rd_sel)
  );

  assign ram_w_enable  = |wr_gnt;
  assign ram_w_address = wr_addr_a[wr_sel];
  assign ram_w_data    = wr_data_a[wr_sel];
  assign ram_r_enable  = |rd_gnt;
  assign ram_r_address = rd_addr_a[rd_sel];
  assign rd_data       = ram_r_data;

  // The RAM's read register and this strobe line up, tagging data with its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_gnt;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a stub RAM, a rule-level arbitration
// and memory model, and a monitor that matches every rd_valid strobe.

module tb_ram_port_arbiter;
  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     wr_req, rd_req, wr_gnt, rd_gnt, rd_valid;
  logic [NP*AW-1:0]  wr_address, rd_address;
  logic [NP*DW-1:0]  wr_data;
  logic [DW-1:0]     rd_data, ram_w_data;
  logic [DW-1:0]     ram_r_data = '0;
  logic              ram_w_enable, ram_r_enable;
  logic [AW-1:0]     ram_w_address, ram_r_address;

  logic [AW-1:0] wa [NP];
  logic [AW-1:0] ra [NP];
  logic [DW-1:0] wd [NP];

  for (genvar i = 0; i < NP; i++) begin : g_pack
    assign wr_address[i*AW +: AW] = wa[i];
    assign rd_address[i*AW +: AW] = ra[i];
    assign wr_data[i*DW +: DW]    = wd[i];
  end

  ram_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SIZE(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_req        (wr_req),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .wr_gnt        (wr_gnt),
    .rd_req        (rd_req),
    .rd_address    (rd_address),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .ram_w_enable  (ram_w_enable),
    .ram_w_address (ram_w_address),
    .ram_w_data    (ram_w_data),
    .ram_r_enable  (ram_r_enable),
    .ram_r_address (ram_r_address),
    .ram_r_data    (ram_r_data)
  );

  always #5 clk = ~clk;

  // Stub RAM: write port plus registered read port, read-before-write.
  logic [DW-1:0] ram_mem [DEPTH];
  bit            mem_clear = 1'b1;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
      mem_clear <= 1'b0;
    end else begin
      if (ram_w_enable) ram_mem[ram_w_address] <= ram_w_data;
      if (ram_r_enable) ram_r_data <= ram_mem[ram_r_address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pointers, memory contents, expected read returns.
  typedef struct {
    int cyc;
    int port;
    int data;
  } exp_t;

  exp_t          exp_q [$];
  int            m_wr_ptr = 0;
  int            m_rd_ptr = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  function automatic int pick(input logic [NP-1:0] req, input int ptr);
    for (int k = 0; k < NP; k++) begin
      if (req[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  // Monitor: each cycle either the next expected return or silence.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rd_valid_in_reset", int'(rd_valid), 0);
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd_valid", int'(rd_valid), 1 << e.port);
      chk("rd_data", int'(rd_data), e.data);
    end else begin
      chk("rd_valid_idle", int'(rd_valid), 0);
    end
  end

  // Called at posedge+1 with inputs already driven; checks this cycle, advances one clock.
  task automatic step();
    int ew, er;
    #2;
    chk("wr_ptr", int'(dut.u_wr_arb.ptr), m_wr_ptr);
    chk("rd_ptr", int'(dut.u_rd_arb.ptr), m_rd_ptr);
    ew = pick(wr_req, m_wr_ptr);
    er = pick(rd_req, m_rd_ptr);
    chk("wr_gnt", int'(wr_gnt), (ew >= 0) ? (1 << ew) : 0);
    chk("rd_gnt", int'(rd_gnt), (er >= 0) ? (1 << er) : 0);
    chk("ram_w_enable", int'(ram_w_enable), (ew >= 0) ? 1 : 0);
    chk("ram_r_enable", int'(ram_r_enable), (er >= 0) ? 1 : 0);
    if (ew >= 0) begin
      chk("ram_w_address", int'(ram_w_address), int'(wa[ew]));
      chk("ram_w_data", int'(ram_w_data), int'(wd[ew]));
    end
    if (er >= 0) begin
      chk("ram_r_address", int'(ram_r_address), int'(ra[er]));
      exp_q.push_back('{cyc: cyc, port: er, data: int'(ref_mem[ra[er]])});
      m_rd_ptr = (er + 1) % NP;
    end
    if (ew >= 0) begin
      ref_mem[wa[ew]] = wd[ew];
      m_wr_ptr = (ew + 1) % NP;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset asynchronously, checks outputs are forced low, releases away from the edge.
  task automatic do_reset();
    wr_req = '1;
    rd_req = '1;
    rst_n  = 1'b0;
    #1;
    chk("rst_wr_gnt", int'(wr_gnt), 0);
    chk("rst_rd_gnt", int'(rd_gnt), 0);
    chk("rst_ram_w_enable", int'(ram_w_enable), 0);
    chk("rst_ram_r_enable", int'(ram_r_enable), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    @(negedge clk);
    wr_req = '0;
    rd_req = '0;
    #1;
    rst_n    = 1'b1;
    m_wr_ptr = 0;
    m_rd_ptr = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    wr_req = '0;
    rd_req = '0;
    for (int i = 0; i < NP; i++) begin
      wa[i] = '0; ra[i] = '0; wd[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #1;
    do_reset();

    // Single port write then read.
    wr_req = 4'b0100; wa[2] = 10'h005; wd[2] = 8'hA5;
    step();
    wr_req = '0; rd_req = 4'b0100; ra[2] = 10'h005;
    step();
    rd_req = '0;
    step();

    // Round-robin fairness from reset on both paths.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      wr_req = '1; rd_req = '1;
      for (int i = 0; i < NP; i++) begin
        wa[i] = AW'($urandom_range(0, 31));
        ra[i] = AW'($urandom_range(0, 31));
        wd[i] = DW'($urandom);
      end
      step();
    end

    // Pointer skip and wrap: bring wr_ptr to 3, then only ports 1 and 3 request.
    rd_req = '0;
    wr_req = 4'b0100;
    step();
    wr_req = 4'b1010;
    step();
    step();
    wr_req = '0;
    step();

    // Same-cycle read and write to one address: old data, then new.
    wr_req = 4'b0001; wa[0] = 10'h010; wd[0] = 8'h11;
    step();
    wr_req = 4'b0001; wd[0] = 8'h22;
    rd_req = 4'b0010; ra[1] = 10'h010;
    step();
    wr_req = '0;
    step();
    rd_req = '0;
    step();

    // Reset in the cycle after a read grant: in-flight return is dropped.
    rd_req = 4'b0001; ra[0] = 10'h010;
    step();
    do_reset();
    wr_req = '1; rd_req = '1;
    step();
    wr_req = '0; rd_req = '0;
    step();

    // Idle: nothing moves.
    for (int n = 0; n < 10; n++) step();

    // Randomized traffic over a small address window to provoke hazards.
    for (int n = 0; n < 300; n++) begin
      wr_req = NP'($urandom_range(0, 15));
      rd_req = NP'($urandom_range(0, 15));
      for (int i = 0; i < NP; i++) begin
        wa[i] = AW'($urandom_range(0, 15));
        ra[i] = AW'($urandom_range(0, 15));
        wd[i] = DW'($urandom);
      end
      step();
    end
    wr_req = '0; rd_req = '0;
    for (int n = 0; n < 3; n++) step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
